// File: rtl/pipe_stage_elastic_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic_pkg
//
// Shared types for the elastic pipeline-stage register and the CPU stage
// payloads it carries.
//   pipe_state_t : occupancy state of one elastic stage (EMPTY / ONE / TWO).
//   ifid_t, idex_t, exmem_t, memwb_t : packed per-stage payloads. Each stage
//     instantiates pipe_stage_elastic with DATA_W = $bits(<struct>) and
//     BUBBLE_VAL = <STAGE>_NOP.
//   *_NOP constants : bubble payloads. Every write-enable, memory-enable and
//     halt bit is clear, so a bubble has no architectural side effect.
//   occ_of() : maps a stage state to its entry count.
// -----------------------------------------------------------------------------
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Fetch -> decode
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  // Decode -> execute
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [4:0]  wsel;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        memtoreg;
    logic        regWr;
    logic        dWEN;
    logic        dREN;
    logic        halt;
  } idex_t;

  // Execute -> memory
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu_out;
    logic [31:0] wdat;
    logic [4:0]  wsel;
    logic        memtoreg;
    logic        regWr;
    logic        dWEN;
    logic        dREN;
    logic        halt;
  } exmem_t;

  // Memory -> writeback
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu_out;
    logic [31:0] dload;
    logic [4:0]  wsel;
    logic        memtoreg;
    logic        regWr;
    logic        halt;
  } memwb_t;

  // An all-zero instruction word is the canonical NOP (sll $0,$0,0). All
  // control bits are clear in every stage, so zero is a safe bubble.
  localparam ifid_t  IFID_NOP  = '0;
  localparam idex_t  IDEX_NOP  = '0;
  localparam exmem_t EXMEM_NOP = '0;
  localparam memwb_t MEMWB_NOP = '0;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic_sat_counter
//
// Saturating event counter, intended for reuse by other performance counters.
// It counts up by one on every clock edge where inc=1 and holds at all-ones
// instead of wrapping.
//   CLK   in  1  clock
//   RST   in  1  synchronous active-high reset; clears count to 0
//   inc   in  1  count this cycle
//   count out W  current count
// -----------------------------------------------------------------------------
module pipe_stage_elastic_sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count_p0;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX_VAL) ? MAX_VAL : (v + ONE_VAL);
  endfunction

  // ---- stage p0: count register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count_p0 <= '0;
    end else if (inc) begin
      r_count_p0 <= sat_inc(r_count_p0);
    end
  end

  assign count = r_count_p0;

endmodule

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Reusable pipeline-stage register with a valid/ready handshake, synchronous
// flush, an optional second (skid) entry and a saturating stall counter.
//
// Parameters
//   DATA_W     payload width
//   SKID_EN    1: two entries, in_ready is a register decode (no comb path
//              from out_ready); 0: one entry, in_ready = empty | out_ready
//   BUBBLE_VAL payload presented on out_data whenever out_valid=0
//   CNT_W      stall counter width
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   flush                drop all held entries and the entry offered now
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data oldest entry
//   occupancy            held entries (0..2)
//   stall_cnt            saturating count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter bit                SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       r_state_p0;
  logic [DATA_W-1:0] r_main_p0;   // oldest entry, drives out_data
  logic [DATA_W-1:0] r_skid_p0;   // second entry, only meaningful in TWO

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  // A flushed offer is not a transfer, even if the handshake lines agree.
  assign w_in_fire  = in_valid & in_ready & ~flush;
  assign w_out_fire = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;

  generate
    if (SKID_EN) begin : g_skid_ready
      // Decoded from state only; this is what breaks the ready chain.
      assign in_ready = (r_state_p0 != TWO);
    end else begin : g_flop_ready
      // Single entry: a full register can still accept if it drains now.
      assign in_ready = (r_state_p0 == EMPTY) | out_ready;
    end
  endgenerate

  // ---- stage p0: state and data registers ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_p0 <= EMPTY;
      r_main_p0  <= BUBBLE_VAL;
      r_skid_p0  <= BUBBLE_VAL;
    end else if (flush) begin
      // Any out_fire this cycle has already been seen downstream; only the
      // held entries and the current offer are discarded.
      r_state_p0 <= EMPTY;
      r_main_p0  <= BUBBLE_VAL;
      r_skid_p0  <= BUBBLE_VAL;
    end else begin
      case (r_state_p0)
        EMPTY: begin
          if (w_in_fire) begin
            r_state_p0 <= ONE;
            r_main_p0  <= in_data;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_p0 <= in_data;
          end else if (w_in_fire) begin
            // Only reachable with SKID_EN=1; in single-register mode
            // in_ready is low whenever ONE is not draining.
            r_state_p0 <= TWO;
            r_skid_p0  <= in_data;
          end else if (w_out_fire) begin
            r_state_p0 <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_state_p0 <= ONE;
            r_main_p0  <= r_skid_p0;
          end
        end
        default: begin
          r_state_p0 <= EMPTY;
        end
      endcase
    end
  end

  assign out_valid = (r_state_p0 != EMPTY);
  // r_main_p0 keeps stale data after draining, so the bubble is muxed in.
  assign out_data  = out_valid ? r_main_p0 : BUBBLE_VAL;
  assign occupancy = occ_of(r_state_p0);

  pipe_stage_elastic_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Drives one skid-mode and one single-register instance from shared inputs and
// compares both against queue-based models of an elastic stage every cycle.
// Directed sequences with literal expectations come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int             DW     = 16;
  localparam int             CW     = 4;
  localparam logic [DW-1:0]  BUB    = 16'hDEAD;
  localparam int             SATMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occ;
  logic [CW-1:0] s_stall;

  logic          f_in_ready, f_out_valid;
  logic [DW-1:0] f_out_data;
  logic [1:0]    f_occ;
  logic [CW-1:0] f_stall;

  int n_cmp = 0;
  int n_bad = 0;

  // Models: a FIFO of held entries plus a saturating stall count per instance.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  int            st_s = 0;
  int            st_f = 0;
  bit            m_live = 1'b0;

  always #5 CLK = ~CLK;

  pipe_stage_elastic #(
    .DATA_W(DW), .SKID_EN(1'b1), .BUBBLE_VAL(BUB), .CNT_W(CW)
  ) u_skid (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  pipe_stage_elastic #(
    .DATA_W(DW), .SKID_EN(1'b0), .BUBBLE_VAL(BUB), .CNT_W(CW)
  ) u_flop (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(f_in_ready), .in_data(in_data),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
    .occupancy(f_occ), .stall_cnt(f_stall)
  );

  function automatic bit m_rdy(int sz, bit skid, bit ordy);
    return skid ? (sz < 2) : ((sz == 0) || ordy);
  endfunction

  function automatic logic [DW-1:0] m_out_s();
    return (q_s.size() > 0) ? q_s[0] : BUB;
  endfunction

  function automatic logic [DW-1:0] m_out_f();
    return (q_f.size() > 0) ? q_f[0] : BUB;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic pin(string nm, logic [31:0] dut, logic [31:0] mdl, logic [31:0] exp);
    chk({nm, " dut"}, dut, exp);
    chk({nm, " model"}, mdl, exp);
  endtask

  task automatic check_all();
    chk("s_in_ready",  32'(s_in_ready),  32'(m_rdy(q_s.size(), 1'b1, out_ready)));
    chk("s_out_valid", 32'(s_out_valid), 32'(q_s.size() > 0));
    chk("s_out_data",  32'(s_out_data),  32'(m_out_s()));
    chk("s_occ",       32'(s_occ),       32'(q_s.size()));
    chk("s_stall",     32'(s_stall),     32'(st_s));
    chk("f_in_ready",  32'(f_in_ready),  32'(m_rdy(q_f.size(), 1'b0, out_ready)));
    chk("f_out_valid", 32'(f_out_valid), 32'(q_f.size() > 0));
    chk("f_out_data",  32'(f_out_data),  32'(m_out_f()));
    chk("f_occ",       32'(f_occ),       32'(q_f.size()));
    chk("f_stall",     32'(f_stall),     32'(st_f));
  endtask

  task automatic model_step(bit rst, bit fl, bit iv, logic [DW-1:0] id, bit ordy);
    bit ofire, ifire;
    if (rst) begin
      q_s.delete();
      q_f.delete();
      st_s   = 0;
      st_f   = 0;
      m_live = 1'b1;
    end else begin
      if (q_s.size() > 0 && !ordy && st_s < SATMAX) st_s++;
      if (q_f.size() > 0 && !ordy && st_f < SATMAX) st_f++;

      ofire = (q_s.size() > 0) && ordy;
      ifire = iv && m_rdy(q_s.size(), 1'b1, ordy) && !fl;
      if (fl) q_s.delete();
      else begin
        if (ofire) void'(q_s.pop_front());
        if (ifire) q_s.push_back(id);
      end

      ofire = (q_f.size() > 0) && ordy;
      ifire = iv && m_rdy(q_f.size(), 1'b0, ordy) && !fl;
      if (fl) q_f.delete();
      else begin
        if (ofire) void'(q_f.pop_front());
        if (ifire) q_f.push_back(id);
      end
    end
  endtask

  // One clock: drive at negedge, compare before the edge, advance the model
  // on the edge, return 1 time unit after it so registered outputs can be
  // pinned against literals.
  task automatic cyc(bit rst, bit fl, bit iv, logic [DW-1:0] id, bit ordy);
    @(negedge CLK);
    RST       = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    if (m_live) check_all();
    @(posedge CLK);
    model_step(rst, fl, iv, id, ordy);
    #1;
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    pin("rst out_valid", 32'(s_out_valid), 32'(q_s.size() > 0), 32'd0);
    pin("rst out_data",  32'(s_out_data),  32'(m_out_s()),      32'hDEAD);
    pin("rst occ",       32'(s_occ),       32'(q_s.size()),     32'd0);
    pin("rst in_ready",  32'(s_in_ready),  32'(m_rdy(q_s.size(), 1'b1, out_ready)), 32'd1);
    pin("rst stall",     32'(s_stall),     32'(st_s),           32'd0);

    // Streaming 1,2,3 with out_ready high
    cyc(1'b0, 1'b0, 1'b1, 16'h0001, 1'b1);
    pin("stream d1", 32'(s_out_data), 32'(m_out_s()), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 16'h0002, 1'b1);
    pin("stream d2", 32'(s_out_data), 32'(m_out_s()), 32'h2);
    cyc(1'b0, 1'b0, 1'b1, 16'h0003, 1'b1);
    pin("stream d3",    32'(s_out_data), 32'(m_out_s()),  32'h3);
    pin("stream occ",   32'(s_occ),      32'(q_s.size()), 32'd1);
    pin("stream stall", 32'(s_stall),    32'(st_s),       32'd0);
    pin("stream f d3",  32'(f_out_data), 32'(m_out_f()),  32'h3);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Back-pressure: A, B held; C refused until the stage drains
    cyc(1'b0, 1'b0, 1'b1, 16'h000A, 1'b0);
    pin("bp head A", 32'(s_out_data), 32'(m_out_s()), 32'hA);
    cyc(1'b0, 1'b0, 1'b1, 16'h000B, 1'b0);
    pin("bp occ2",      32'(s_occ),      32'(q_s.size()), 32'd2);
    pin("bp s_rdy0",    32'(s_in_ready), 32'(m_rdy(q_s.size(), 1'b1, out_ready)), 32'd0);
    pin("bp f occ1",    32'(f_occ),      32'(q_f.size()), 32'd1);
    pin("bp f_rdy0",    32'(f_in_ready), 32'(m_rdy(q_f.size(), 1'b0, out_ready)), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b0);
    pin("bp occ2 hold", 32'(s_occ),      32'(q_s.size()), 32'd2);
    pin("bp stall2",    32'(s_stall),    32'(st_s),       32'd2);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b1);
    pin("bp head B",    32'(s_out_data), 32'(m_out_s()),  32'hB);
    pin("bp f head C",  32'(f_out_data), 32'(m_out_f()),  32'hC);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b1);
    pin("bp head C",    32'(s_out_data), 32'(m_out_s()),  32'hC);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    pin("bp stall end", 32'(s_stall),    32'(st_s),       32'd2);
    pin("bp f stall",   32'(f_stall),    32'(st_f),       32'd2);

    // Flush while full, with a simultaneous offer of 7
    cyc(1'b0, 1'b0, 1'b1, 16'h0005, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0006, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h0007, 1'b0);
    pin("fl out_valid", 32'(s_out_valid), 32'(q_s.size() > 0), 32'd0);
    pin("fl out_data",  32'(s_out_data),  32'(m_out_s()),      32'hDEAD);
    pin("fl occ",       32'(s_occ),       32'(q_s.size()),     32'd0);
    pin("fl stall",     32'(s_stall),     32'(st_s),           32'd4);
    pin("fl f stall",   32'(f_stall),     32'(st_f),           32'd4);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Stall counter saturation
    repeat (20) cyc(1'b0, 1'b0, 1'b1, 16'h0009, 1'b0);
    pin("sat s", 32'(s_stall), 32'(st_s), 32'd15);
    pin("sat f", 32'(f_stall), 32'(st_f), 32'd15);

    // Reset mid-operation, together with flush and an offer
    cyc(1'b1, 1'b1, 1'b1, 16'h0008, 1'b1);
    pin("rmid occ",   32'(s_occ),      32'(q_s.size()), 32'd0);
    pin("rmid rdy",   32'(s_in_ready), 32'(m_rdy(q_s.size(), 1'b1, out_ready)), 32'd1);
    pin("rmid stall", 32'(s_stall),    32'(st_s),       32'd0);
    pin("rmid f stall", 32'(f_stall),  32'(st_f),       32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 9) < 7,
          DW'($urandom),
          $urandom_range(0, 9) < 6);
    end
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Generic, parametrised pipeline-stage register that replaces the fixed per-stage register interfaces (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. The payload is an opaque packed vector. The block adds a valid/ready handshake, synchronous flush (bubble insertion), an optional 2-entry skid buffer that cuts the combinational ready path, and a saturating stall-cycle counter. It sits between any two datapath stages; the hazard unit drives flush, and downstream back-pressure drives out_ready.

Parameters:
DATA_W, 64, payload width in bits.
SKID_EN, 1, 1 = 2-entry skid mode (in_ready is registered); 0 = single-register mode (in_ready is combinational).
BUBBLE_VAL, '0, DATA_W-bit value driven on out_data whenever out_valid=0; encodes a NOP with regWr/dWEN/dREN/halt clear.
CNT_W, 16, stall counter width.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  synchronous, active-high reset.
flush  in  1  discard all held entries and the entry offered this cycle.
in_valid  in  1  upstream offers in_data.
in_ready  out  1  block accepts in_data this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data holds a live entry.
out_ready  in  1  downstream consumes out_data this cycle.
out_data  out  DATA_W  oldest held payload, or BUBBLE_VAL when out_valid=0.
occupancy  out  2  number of held entries (0..2).
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake terms: in_fire = in_valid & in_ready & !flush; out_fire = out_valid & out_ready.
- Reset, on a rising edge with RST=1:
  - state = EMPTY; main and skid data = BUBBLE_VAL; stall_cnt = 0.
  - Outputs after reset: out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1.
  - RST overrides flush and all handshakes, including mid-transfer.
- States (pipe_state_t): EMPTY (occupancy 0), ONE (main valid, occupancy 1), TWO (main and skid valid, occupancy 2; reachable only when SKID_EN=1).
- Outputs: out_valid = (state != EMPTY); out_data = main when out_valid, else BUBBLE_VAL.
- in_ready:
  - SKID_EN=1: in_ready = (state != TWO), a pure function of registered state with no combinational path from out_ready.
  - SKID_EN=0: in_ready = (state == EMPTY) | out_ready.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire & out_fire -> ONE, main <= in_data.
  - ONE, in_fire & !out_fire -> TWO, skid <= in_data. Under SKID_EN=0 in_ready is 0 in this case, so the transition cannot occur.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither fire -> hold.
  - TWO: in_ready=0. out_fire -> ONE, main <= skid. No out_fire -> hold.
- Ordering: strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush, synchronous, priority below RST and above everything else:
  - Next state = EMPTY; main and skid <= BUBBLE_VAL.
  - The in_data offered in the flush cycle is discarded even if in_valid & in_ready.
  - An out_fire in the flush cycle still completes, so downstream consumes the current out_data normally.
  - stall_cnt is not cleared by flush.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput is 1 entry/cycle with out_ready held high in both modes.
- stall_cnt increments when out_valid & !out_ready and saturates at 2^CNT_W-1 (no wrap).
- Data registers load only on the transitions listed above. No X propagates to out_data while out_valid=0.

Decomposition:
- cpu_types_pkg additions:
  - pipe_state_t enum {EMPTY, ONE, TWO}, 2 bits.
  - Packed payload structs ifid_t, idex_t, exmem_t, memwb_t, so each stage instantiates with DATA_W = $bits(<struct>) and BUBBLE_VAL set to that struct's NOP constant.
  - Constants IDEX_NOP etc.
- One sub-module is natural: sat_counter (parameter W; ports CLK, RST, inc, count), reused by other performance counters.

Test Plan:
- Reset then streaming: after RST, drive in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles and out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later each, out_valid continuous, occupancy 1, stall_cnt 0.
- Back-pressure (SKID_EN=1): fill with 0xA, 0xB while out_ready=0 -> occupancy 2, in_ready=0 in the next cycle, in_data 0xC not accepted. Raise out_ready -> out 0xA, 0xB, then 0xC, with no loss or duplication. stall_cnt = number of out_ready=0 cycles with out_valid=1.
- Flush with a simultaneous offer: occupancy 2 (0x5, 0x6), assert flush with in_valid=1 and data 0x7 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy 0. 0x7 never appears.
- SKID_EN=0 mode: in ONE with out_ready=0 -> in_ready=0. Toggle out_ready=1 in the same cycle -> in_ready=1 combinationally and main is replaced at the edge.
- Counter saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15. RST returns it to 0.
- Reset mid-operation: occupancy 2, assert RST together with flush and in_valid -> next cycle state EMPTY, in_ready=1, stall_cnt=0.
